// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time configuration sequencer: freezes every core, writes its ID and cache/CCE
// modes over a flow-controlled register bus, then unfreezes all cores and signals done.
module bp_cfg_boot_sequencer #(
    parameter int num_core_p        = 1,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 32,
    parameter int max_outstanding_p = 4,
    parameter int cache_mode_p      = 1,
    parameter int cce_mode_p        = 1,
    localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_v_i,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_DRAIN,
        S_UNFREEZE,
        S_FINAL_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic [core_w_lp-1:0] core_q, core_d;
    logic [cnt_w_lp-1:0]  out_cnt_q, out_cnt_d;
    logic                 err_q, err_d;

    logic                 issue_phase;
    logic                 at_max;
    logic                 last_core;
    logic                 hs;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            core_q    <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            core_q    <= core_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        core_d     = core_q;
        out_cnt_d  = out_cnt_q;
        err_d      = err_q;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;

        issue_phase = (state_q == S_CONFIG) || (state_q == S_UNFREEZE);
        at_max      = (out_cnt_q == cnt_w_lp'(max_outstanding_p));
        last_core   = (core_q == core_w_lp'(num_core_p - 1));
        // A same-cycle ack frees a slot, so a full window may still issue.
        cfg_v_o     = issue_phase && (!at_max || cfg_ack_v_i);
        hs          = cfg_v_o && cfg_ready_i;

        if (cfg_ack_v_i && (out_cnt_q == '0)) begin
            err_d = 1'b1;
        end
        if (hs && !cfg_ack_v_i) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!hs && cfg_ack_v_i && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end

        if (state_q == S_CONFIG) begin
            cfg_core_o = core_q;
            cfg_addr_o = cfg_addr_width_p'(step_q + 3'd1);
            case (step_q)
                3'd0:    cfg_data_o = cfg_data_width_p'(1);
                3'd1:    cfg_data_o = cfg_data_width_p'(core_q);
                3'd2:    cfg_data_o = cfg_data_width_p'(cache_mode_p);
                3'd3:    cfg_data_o = cfg_data_width_p'(cache_mode_p);
                default: cfg_data_o = cfg_data_width_p'(cce_mode_p);
            endcase
        end else if (state_q == S_UNFREEZE) begin
            cfg_core_o = core_q;
            cfg_addr_o = cfg_addr_width_p'(1);
        end

        case (state_q)
            S_IDLE: state_d = S_CONFIG;
            S_CONFIG: begin
                if (hs) begin
                    if (step_q == 3'd4) begin
                        step_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_d == '0) state_d = S_UNFREEZE;
            end
            S_UNFREEZE: begin
                if (hs) begin
                    if (last_core) begin
                        core_d  = '0;
                        state_d = S_FINAL_DRAIN;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end
            end
            S_FINAL_DRAIN: begin
                if (out_cnt_d == '0) state_d = S_DONE;
            end
            default: state_d = S_DONE;
        endcase
    end

    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Self-checking bench for bp_cfg_boot_sequencer: a write-index/outstanding-count model
// predicts every output each cycle under directed and randomized bus behaviour.
module tb_bp_cfg_boot_sequencer;

    localparam int N      = 3;
    localparam int MAX    = 2;
    localparam int CORE_W = 2;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int CACHE  = 1;
    localparam int CCE    = 0;
    localparam int TOTAL  = 6 * N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ready = 1'b0;
    logic              ack_in = 1'b0;
    logic              cfg_v_o;
    logic [CORE_W-1:0] cfg_core_o;
    logic [AW-1:0]     cfg_addr_o;
    logic [DW-1:0]     cfg_data_o;
    logic              done_o;
    logic              err_o;

    bp_cfg_boot_sequencer #(
        .num_core_p(N), .cfg_addr_width_p(AW), .cfg_data_width_p(DW),
        .max_outstanding_p(MAX), .cache_mode_p(CACHE), .cce_mode_p(CCE)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .cfg_v_o(cfg_v_o), .cfg_ready_i(ready),
        .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .cfg_ack_v_i(ack_in), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Expected write stream and model state
    int exp_core [TOTAL];
    int exp_addr [TOTAL];
    int exp_data [TOTAL];
    int wr_idx, out_m, cyc, first_v_cyc, done_cyc, hs_log_n;
    bit started, drained, done_m, err_m, prev_hs;
    int log_core [64];
    int log_addr [64];
    int log_data [64];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic build_exp();
        for (int c = 0; c < N; c++) begin
            for (int s = 0; s < 5; s++) begin
                exp_core[5*c+s] = c;
                exp_addr[5*c+s] = s + 1;
            end
            exp_data[5*c+0] = 1;
            exp_data[5*c+1] = c;
            exp_data[5*c+2] = CACHE;
            exp_data[5*c+3] = CACHE;
            exp_data[5*c+4] = CCE;
            exp_core[5*N+c] = c;
            exp_addr[5*N+c] = 1;
            exp_data[5*N+c] = 0;
        end
    endtask

    task automatic model_reset();
        wr_idx = 0; out_m = 0; started = 0; drained = 0; done_m = 0; err_m = 0;
        prev_hs = 0; cyc = 0; first_v_cyc = -1; done_cyc = -1; hs_log_n = 0;
    endtask

    // Entered at posedge+1; drives one cycle of inputs, checks at negedge, returns at next posedge+1.
    task automatic cycle(input logic r, input logic a);
        bit ev, hs;
        int pre, on;
        ready = r;
        ack_in = a;
        @(negedge clk);
        ev = started && ((wr_idx < 5*N) || (wr_idx < TOTAL && drained)) && ((out_m < MAX) || a);
        chk("cfg_v", cfg_v_o, ev);
        if (ev) begin
            chk("cfg_core", cfg_core_o, exp_core[wr_idx]);
            chk("cfg_addr", cfg_addr_o, exp_addr[wr_idx]);
            chk("cfg_data", cfg_data_o, exp_data[wr_idx]);
        end
        chk("done", done_o, done_m);
        chk("err", err_o, err_m);
        if (cfg_v_o && r) begin
            if (hs_log_n < 64) begin
                log_core[hs_log_n] = int'(cfg_core_o);
                log_addr[hs_log_n] = int'(cfg_addr_o);
                log_data[hs_log_n] = int'(cfg_data_o);
            end
            hs_log_n++;
        end
        if (cfg_v_o && first_v_cyc < 0) first_v_cyc = cyc;
        if (done_o && done_cyc < 0) done_cyc = cyc;
        hs = ev && r;
        pre = wr_idx;
        if (hs) wr_idx++;
        on = out_m;
        if (hs && !a) on = out_m + 1;
        else if (!hs && a && out_m > 0) on = out_m - 1;
        if (a && out_m == 0) err_m = 1;
        if (started && pre == 5*N && !drained && on == 0) drained = 1;
        if (started && pre == TOTAL && on == 0) done_m = 1;
        started = 1;
        out_m = on;
        prev_hs = hs;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        ready = 1'b0;
        ack_in = 1'b0;
        #1;
        chk("rst_v", cfg_v_o, 0);
        chk("rst_core", cfg_core_o, 0);
        chk("rst_addr", cfg_addr_o, 0);
        chk("rst_data", cfg_data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Ready always high, each write acknowledged the cycle after its handshake.
    task automatic run_nominal(input string tag);
        for (int k = 0; k < 100 && !done_m; k++) cycle(1'b1, prev_hs);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk({tag, "_done_end"}, done_o, 1);
        chk({tag, "_first_v_cycle"}, first_v_cyc, 1);
        chk({tag, "_done_cycle"}, done_cyc, 21);
        chk({tag, "_hs_total"}, hs_log_n, 18);
        chk({tag, "_w0_addr"}, log_addr[0], 1);
        chk({tag, "_w0_data"}, log_data[0], 1);
        chk({tag, "_w6_core"}, log_core[6], 1);
        chk({tag, "_w6_data"}, log_data[6], 1);
        chk({tag, "_w14_data"}, log_data[14], 0);
        chk({tag, "_w15_core"}, log_core[15], 0);
        chk({tag, "_w17_core"}, log_core[17], 2);
        chk({tag, "_w17_addr"}, log_addr[17], 1);
        chk({tag, "_w17_data"}, log_data[17], 0);
    endtask

    initial begin
        build_exp();
        model_reset();
        @(posedge clk);
        #1;

        do_reset();
        run_nominal("nom");

        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("spur_err", err_o, 1);
        chk("spur_done", done_o, 1);

        do_reset();
        for (int k = 0; k < 2000 && !done_m; k++)
            cycle(1'(($urandom_range(0, 1))), 1'((out_m > 0) && ($urandom_range(0, 1) == 1)));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("bp_done", done_o, 1);
        chk("bp_err", err_o, 0);
        chk("bp_hs_total", hs_log_n, 18);
        chk("bp_w17_core", log_core[17], 2);

        do_reset();
        repeat (7) cycle(1'b1, 1'b0);
        chk("win_hs_after_withhold", hs_log_n, 2);
        chk("win_v_gated", cfg_v_o, 0);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);
        chk("win_one_release", hs_log_n, 3);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("win_hs_ack_at_max", hs_log_n, 5);
        for (int k = 0; k < 2000 && wr_idx <= 5*N; k++)
            cycle(1'(($urandom_range(0, 1))), 1'((out_m > 0) && ($urandom_range(0, 1) == 1)));
        chk("mid_not_done", done_o, 0);
        do_reset();
        run_nominal("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
